sqrt_seq: RTL and testbench

- Parametrised, handshaked successor to the team's 32-bit bit-serial integer square-root unit.
- Computes floor(sqrt(x)) or round-to-nearest sqrt(x) of a WIDTH-bit unsigned operand, one result bit per clock, and also returns the exact remainder.
- Sits between a valid/ready producer and a valid/ready consumer in datapath test rigs.
- Adds over the previous unit: backpressure, remainder output, rounding mode and synchronous abort.

---
 rtl/sqrt_seq.sv | 105 ++++++++++
 tb/tb_sqrt_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_seq.sv
// Bit-serial restoring integer square root with valid/ready handshakes.
// Produces one root bit per clock, plus the exact floor remainder and optional rounding.
module sqrt_seq #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic               round_en,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH/2:0]   root,
   output logic [WIDTH/2:0]   rem
);

   localparam int W2    = WIDTH / 2;
   localparam int CNT_W = $clog2(WIDTH / 2 + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] x_q;
   logic             round_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W2-1:0]    q_q;
   logic [W2+1:0]    r_q;
   logic [W2:0]      root_q;
   logic [W2:0]      rem_q;

   logic [W2+1:0]    r_shift;
   logic [W2+1:0]    trial;
   logic [W2+1:0]    r_sub;
   logic [W2+1:0]    r_d;
   logic [W2-1:0]    q_d;
   logic             take;
   logic             round_up;
   logic [W2:0]      root_rnd;

   // The operand shadow shifts left two bits per step, so the current bit pair is always its top.
   always_comb begin
      r_shift  = (r_q << 2) | {{W2{1'b0}}, x_q[WIDTH-1 -: 2]};
      trial    = {q_q, 2'b01};
      take     = (r_shift >= trial);
      r_sub    = r_shift - trial;
      r_d      = take ? r_sub : r_shift;
      q_d      = (q_q << 1) | {{(W2-1){1'b0}}, take};
      round_up = (r_d[W2:0] > {1'b0, q_d});
      root_rnd = {1'b0, q_d} + {{W2{1'b0}}, round_up};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         round_q <= 1'b0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         root_q  <= '0;
         rem_q   <= '0;
      end else if (abort) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q     <= x;
                  round_q <= round_en;
                  q_q     <= '0;
                  r_q     <= '0;
                  cnt_q   <= CNT_W'(W2 - 1);
                  state_q <= CALC;
               end
            end
            CALC: begin
               x_q   <= x_q << 2;
               q_q   <= q_d;
               r_q   <= r_d;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == '0) begin
                  // Remainder never exceeds 2q, so it fits in W2+1 bits.
                  rem_q   <= r_d[W2:0];
                  root_q  <= round_q ? root_rnd : {1'b0, q_d};
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign root      = root_q;
   assign rem       = rem_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// Scoreboard bench for sqrt_seq: a 64-bit and a 16-bit instance, directed vectors,
// a monitor per instance that checks results, latency and hold-stability.
module tb_sqrt_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [127:0] root;
      logic [127:0] rem;
      int           acc;
   } exp_t;

   exp_t q64[$];
   exp_t q16[$];

   // 64-bit instance
   logic        rst64, iv64, ir64, rnd64, ab64, ov64, or64;
   logic [63:0] x64;
   logic [32:0] root64, rem64;

   sqrt_seq #(.WIDTH(64)) dut64 (
      .clk(clk), .reset(rst64), .in_valid(iv64), .in_ready(ir64), .x(x64),
      .round_en(rnd64), .abort(ab64), .out_valid(ov64), .out_ready(or64),
      .root(root64), .rem(rem64)
   );

   // 16-bit instance
   logic        rst16, iv16, ir16, rnd16, ab16, ov16, or16;
   logic [15:0] x16;
   logic [8:0]  root16, rem16;

   sqrt_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(rst16), .in_valid(iv16), .in_ready(ir16), .x(x16),
      .round_en(rnd16), .abort(ab16), .out_valid(ov16), .out_ready(or16),
      .root(root16), .rem(rem16)
   );

   function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitors: compare on the first cycle of out_valid, then check the held values.
   exp_t        e64, e16;
   logic        seen64 = 1'b0, seen16 = 1'b0;
   logic [32:0] hr64, hm64;
   logic [8:0]  hr16, hm16;

   always @(negedge clk) begin
      if (ov64) begin
         if (!seen64) begin
            if (q64.size() == 0) begin
               check("unexpected_out64", 128'(ov64), 128'(0));
            end else begin
               e64 = q64.pop_front();
               check("root64", 128'(root64), e64.root);
               check("rem64", 128'(rem64), e64.rem);
               check("latency64", 128'(cyc - e64.acc), 128'(32));
            end
            hr64 = root64;
            hm64 = rem64;
         end else begin
            check("hold_root64", 128'(root64), 128'(hr64));
            check("hold_rem64", 128'(rem64), 128'(hm64));
         end
      end
      seen64 = ov64 && !or64;
   end

   always @(negedge clk) begin
      if (ov16) begin
         if (!seen16) begin
            if (q16.size() == 0) begin
               check("unexpected_out16", 128'(ov16), 128'(0));
            end else begin
               e16 = q16.pop_front();
               check("root16", 128'(root16), e16.root);
               check("rem16", 128'(rem16), e16.rem);
               check("latency16", 128'(cyc - e16.acc), 128'(8));
            end
            hr16 = root16;
            hm16 = rem16;
         end else begin
            check("hold_root16", 128'(root16), 128'(hr16));
            check("hold_rem16", 128'(rem16), 128'(hm16));
         end
      end
      seen16 = ov16 && !or16;
   end

   task automatic send64(input logic [63:0] xv, input logic r, input bit push,
                         input logic [32:0] er, input logic [32:0] em);
      exp_t e;
      logic was_ready;
      int   n;
      x64   = xv;
      rnd64 = r;
      iv64  = 1'b1;
      n     = 0;
      forever begin
         was_ready = ir64;
         step();
         if (was_ready) break;
         n++;
         if (n > 200) begin
            check("accept_timeout64", 128'(ir64), 128'(1));
            break;
         end
      end
      iv64 = 1'b0;
      x64  = '1;
      if (push) begin
         e.root = 128'(er);
         e.rem  = 128'(em);
         e.acc  = cyc;
         q64.push_back(e);
      end
      $display("tb64: x=%0d round=%0d accepted at cycle %0d", xv, r, cyc);
   endtask

   task automatic send16(input logic [15:0] xv, input logic r, input bit push,
                         input logic [8:0] er, input logic [8:0] em);
      exp_t e;
      logic was_ready;
      int   n;
      x16   = xv;
      rnd16 = r;
      iv16  = 1'b1;
      n     = 0;
      forever begin
         was_ready = ir16;
         step();
         if (was_ready) break;
         n++;
         if (n > 200) begin
            check("accept_timeout16", 128'(ir16), 128'(1));
            break;
         end
      end
      iv16 = 1'b0;
      x16  = '1;
      if (push) begin
         e.root = 128'(er);
         e.rem  = 128'(em);
         e.acc  = cyc;
         q16.push_back(e);
      end
      $display("tb16: x=%0d round=%0d accepted at cycle %0d", xv, r, cyc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q64.size() != 0 || q16.size() != 0 || ov64 || ov16) && n < 500) begin
         step();
         n++;
      end
      check("drain_timeout", 128'(n >= 500), 128'(0));
   endtask

   initial begin
      rst64 = 1'b0; iv64 = 1'b0; x64 = '0; rnd64 = 1'b0; ab64 = 1'b0; or64 = 1'b1;
      rst16 = 1'b0; iv16 = 1'b0; x16 = '0; rnd16 = 1'b0; ab16 = 1'b0; or16 = 1'b1;
      step();
      step();
      check("rst_in_ready64", 128'(ir64), 128'(1));
      check("rst_out_valid64", 128'(ov64), 128'(0));
      check("rst_root64", 128'(root64), 128'(0));
      check("rst_rem64", 128'(rem64), 128'(0));
      check("rst_in_ready16", 128'(ir16), 128'(1));
      check("rst_out_valid16", 128'(ov16), 128'(0));
      rst64 = 1'b1;
      rst16 = 1'b1;
      step();

      // Directed values
      send64(64'd0, 1'b0, 1'b1, 33'd0, 33'd0);
      send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 33'd4294967295, 33'd8589934590);
      send64(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 33'd4294967296, 33'd8589934590);
      send64(64'd24, 1'b1, 1'b1, 33'd5, 33'd8);
      send64(64'd20, 1'b1, 1'b1, 33'd4, 33'd4);
      send64(64'h4000_0000_0000_0000, 1'b0, 1'b1, 33'd2147483648, 33'd0);
      drain();

      // Abort in IDLE blocks acceptance
      x64 = 64'd7; iv64 = 1'b1; ab64 = 1'b1;
      step();
      check("idle_abort_in_ready", 128'(ir64), 128'(1));
      iv64 = 1'b0; ab64 = 1'b0;
      step();

      // Backpressure: hold out_ready low for 10 cycles with a new operand waiting
      or64 = 1'b0;
      send64(64'd100, 1'b0, 1'b1, 33'd10, 33'd0);
      for (int i = 0; i < 100 && !ov64; i++) step();
      x64 = 64'd49; rnd64 = 1'b0; iv64 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("bp_in_ready", 128'(ir64), 128'(0));
         check("bp_out_valid", 128'(ov64), 128'(1));
         step();
      end
      or64 = 1'b1;
      step();
      check("bp_release_in_ready", 128'(ir64), 128'(1));
      check("bp_release_out_valid", 128'(ov64), 128'(0));
      begin
         exp_t e;
         e.root = 128'(7); e.rem = 128'(0); e.acc = cyc + 1;
         q64.push_back(e);
      end
      step();
      check("bp_next_accepted", 128'(ir64), 128'(0));
      iv64 = 1'b0;
      drain();

      // Abort at CALC iteration 10: no result may appear
      send64(64'd12345, 1'b0, 1'b0, 33'd0, 33'd0);
      repeat (9) step();
      ab64 = 1'b1;
      step();
      ab64 = 1'b0;
      check("abort_in_ready", 128'(ir64), 128'(1));
      check("abort_out_valid", 128'(ov64), 128'(0));
      repeat (40) step();
      send64(64'd81, 1'b0, 1'b1, 33'd9, 33'd0);
      drain();

      // Asynchronous reset mid-CALC, between edges
      send64(64'd999, 1'b0, 1'b0, 33'd0, 33'd0);
      repeat (5) step();
      #3;
      rst64 = 1'b0;
      #1;
      check("arst_in_ready64", 128'(ir64), 128'(1));
      check("arst_out_valid64", 128'(ov64), 128'(0));
      check("arst_root64", 128'(root64), 128'(0));
      check("arst_rem64", 128'(rem64), 128'(0));
      step();
      rst64 = 1'b1;
      repeat (40) step();

      // 16-bit instance
      send16(16'd65535, 1'b0, 1'b1, 9'd255, 9'd510);
      drain();
      send16(16'd1000, 1'b0, 1'b0, 9'd0, 9'd0);
      repeat (3) step();
      #3;
      rst16 = 1'b0;
      #1;
      check("arst_in_ready16", 128'(ir16), 128'(1));
      check("arst_out_valid16", 128'(ov16), 128'(0));
      check("arst_root16", 128'(root16), 128'(0));
      check("arst_rem16", 128'(rem16), 128'(0));
      step();
      rst16 = 1'b1;
      repeat (20) step();

      check("queues_empty", 128'(q64.size() + q16.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
